// File: rtl/router_bus_arbiter.sv
// Shared-bus fabric: round-robin pop from terminal source FIFOs, destination-ID
// routing into per-terminal output FIFOs with all-or-nothing broadcast and drop counting.
module router_bus_arbiter #(
  parameter int unsigned     NUM_NTRFS  = 4,
  parameter int unsigned     PCKG_SZ    = 16,
  parameter int unsigned     ID_W       = 8,
  parameter logic [ID_W-1:0] BROADCAST  = {ID_W{1'b1}},
  parameter bit              BCAST_SELF = 1'b0,
  parameter int unsigned     FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_NTRFS-1:0]           pndng_i_in,
  input  logic [NUM_NTRFS*PCKG_SZ-1:0]   data_out_i_in,
  output logic [NUM_NTRFS-1:0]           popin,
  input  logic [NUM_NTRFS-1:0]           pop,
  output logic [NUM_NTRFS-1:0]           pndng,
  output logic [NUM_NTRFS*PCKG_SZ-1:0]   data_out,
  output logic [15:0]                    drop_cnt,
  output logic                           busy
);

  localparam int unsigned IDX_W = (NUM_NTRFS > 1) ? $clog2(NUM_NTRFS) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t               state;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     grant;
  logic                 grant_vld;
  int unsigned          rr_idx;
  logic [PCKG_SZ-1:0]   pkt_q;
  logic [ID_W-1:0]      dst;
  logic                 dst_uni;
  logic                 dst_bcast;
  logic                 drop;
  logic                 blocked;
  logic [NUM_NTRFS-1:0] targets;
  logic [NUM_NTRFS-1:0] full;
  logic [NUM_NTRFS-1:0] push_vec;
  logic [NUM_NTRFS-1:0] pop_ok;

  logic [PCKG_SZ-1:0]   mem    [NUM_NTRFS][FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr [NUM_NTRFS];
  logic [PTR_W-1:0]     wr_ptr [NUM_NTRFS];
  logic [CNT_W-1:0]     cnt    [NUM_NTRFS];

  // Round-robin search starting one past the last served terminal
  always_comb begin
    grant     = last_grant;
    grant_vld = 1'b0;
    rr_idx    = 0;
    for (int unsigned k = 1; k <= NUM_NTRFS; k++) begin
      rr_idx = (32'(last_grant) + k) % NUM_NTRFS;
      if (!grant_vld && pndng_i_in[IDX_W'(rr_idx)]) begin
        grant     = IDX_W'(rr_idx);
        grant_vld = 1'b1;
      end
    end
  end

  // Destination decode into a target set; a broadcast may exclude its source
  always_comb begin
    dst       = pkt_q[PCKG_SZ-1 -: ID_W];
    dst_uni   = (32'(dst) < NUM_NTRFS);
    dst_bcast = (dst == BROADCAST);
    targets   = '0;
    if (dst_uni) begin
      targets[dst[IDX_W-1:0]] = 1'b1;
    end else if (dst_bcast) begin
      targets = '1;
      if (!BCAST_SELF) targets[winner] = 1'b0;
    end
  end

  assign drop     = !dst_uni && !dst_bcast;
  assign blocked  = |(targets & full);
  assign push_vec = (state == PUSH && !drop && !blocked) ? targets : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      winner     <= '0;
      last_grant <= IDX_W'(NUM_NTRFS - 1);
      pkt_q      <= '0;
      popin      <= '0;
      busy       <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      popin <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            winner <= grant;
            popin  <= NUM_NTRFS'(1) << grant;
            state  <= POP;
            busy   <= 1'b1;
          end
        end
        POP: begin
          pkt_q <= data_out_i_in[32'(winner)*PCKG_SZ +: PCKG_SZ];
          state <= PUSH;
        end
        PUSH: begin
          // Hold until every target has room, so a broadcast is never split
          if (drop || !blocked) begin
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            last_grant <= winner;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_NTRFS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_NTRFS; i++) begin
        if (push_vec[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop_ok[i])   rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push_vec[i] && !pop_ok[i])      cnt[i] <= cnt[i] + CNT_W'(1);
        else if (!push_vec[i] && pop_ok[i]) cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset; emptiness is tracked by the counters
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_NTRFS; i++) begin
      if (push_vec[i]) mem[i][wr_ptr[i]] <= pkt_q;
    end
  end

  for (genvar g = 0; g < NUM_NTRFS; g++) begin : g_out
    assign full[g]   = (cnt[g] == CNT_W'(FIFO_DEPTH));
    assign pop_ok[g] = pop[g] && (cnt[g] != '0);
    assign pndng[g]  = (cnt[g] != '0);
    assign data_out[g*PCKG_SZ +: PCKG_SZ] = (cnt[g] != '0) ? mem[g][rd_ptr[g]] : '0;
  end

endmodule

// File: tb/tb_router_bus_arbiter.sv
// Directed bench for router_bus_arbiter: latency, round-robin order, broadcast,
// backpressure, drop counting and reset behaviour.
module tb_router_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pndng_i_in;
  logic [63:0] data_out_i_in;
  logic [3:0]  pop;
  logic [3:0]  popin, pndng;
  logic [63:0] data_out;
  logic [15:0] drop_cnt;
  logic        busy;
  logic [3:0]  popin_s, pndng_s;
  logic [63:0] data_out_s;
  logic [15:0] drop_cnt_s;
  logic        busy_s;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] src_mem [4][32];
  int          src_rd  [4];
  int          src_wr  [4];
  int          glog    [64];
  int          nlog;
  int          exp_g   [6];
  logic [15:0] exp_d   [6];

  always #5 clk = ~clk;

  router_bus_arbiter #(.NUM_NTRFS(4), .PCKG_SZ(16), .ID_W(8), .BCAST_SELF(1'b0), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in),
    .popin(popin), .pop(pop), .pndng(pndng), .data_out(data_out),
    .drop_cnt(drop_cnt), .busy(busy));

  router_bus_arbiter #(.NUM_NTRFS(4), .PCKG_SZ(16), .ID_W(8), .BCAST_SELF(1'b1), .FIFO_DEPTH(16)) dut_s (
    .clk(clk), .reset(reset), .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in),
    .popin(popin_s), .pop(pop), .pndng(pndng_s), .data_out(data_out_s),
    .drop_cnt(drop_cnt_s), .busy(busy_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_src();
    for (int i = 0; i < 4; i++) begin
      pndng_i_in[i] = (src_rd[i] != src_wr[i]);
      data_out_i_in[i*16 +: 16] = pndng_i_in[i] ? src_mem[i][src_rd[i]] : 16'h0000;
    end
  endtask

  task automatic push_src(input int t, input logic [15:0] v);
    src_mem[t][src_wr[t]] = v;
    src_wr[t]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
    update_src();
  endtask

  // One clock: consume source heads that were strobed, log grants, release pop
  task automatic step();
    logic [3:0] p;
    p = popin;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        src_rd[i]++;
        if (nlog < 64) glog[nlog] = i;
        nlog++;
      end
    end
    pop = 4'b0000;
    update_src();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pop   = 4'b0000;
    clear_src();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    nlog  = 0;
    for (int i = 0; i < 64; i++) glog[i] = -1;
  endtask

  initial begin
    reset = 1'b0;
    pop   = 4'b0000;
    nlog  = 0;
    clear_src();
    #1;
    check("rst_popin", 32'(popin), 32'h0);
    check("rst_pndng", 32'(pndng), 32'h0);
    check("rst_data", data_out[31:0] | data_out[63:32], 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    do_reset();

    // Single unicast 1 -> 2 with cycle-exact latency
    push_src(1, 16'h02AB);
    update_src();
    step();
    check("uni_popin_c1", 32'(popin), 32'h2);
    check("uni_busy_c1", 32'(busy), 32'h1);
    step();
    check("uni_popin_c2", 32'(popin), 32'h0);
    check("uni_pndng_c2", 32'(pndng), 32'h0);
    step();
    check("uni_pndng_c3", 32'(pndng), 32'h4);
    check("uni_data_c3", 32'(data_out[47:32]), 32'h02AB);
    check("uni_busy_c3", 32'(busy), 32'h0);
    pop[2] = 1'b1;
    step();
    check("uni_popped", 32'(pndng), 32'h0);

    // Round-robin among terminals 0, 1, 3 with two packets each, all to FIFO 0
    do_reset();
    for (int n = 0; n < 2; n++) begin
      push_src(0, {8'h00, 4'h0, 4'(n)});
      push_src(1, {8'h00, 4'h1, 4'(n)});
      push_src(3, {8'h00, 4'h3, 4'(n)});
    end
    update_src();
    steps(30);
    check("rr_count", 32'(nlog), 32'd6);
    exp_g = '{0, 1, 3, 0, 1, 3};
    for (int k = 0; k < 6; k++) check($sformatf("rr_grant%0d", k), 32'(glog[k]), 32'(exp_g[k]));
    exp_d = '{16'h0000, 16'h0010, 16'h0030, 16'h0001, 16'h0011, 16'h0031};
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_order%0d", k), 32'(data_out[15:0]), 32'(exp_d[k]));
      pop[0] = 1'b1;
      step();
    end
    check("rr_drained", 32'(pndng), 32'h0);

    // Broadcast from terminal 2, without and with self-delivery
    do_reset();
    push_src(2, 16'hFF55);
    update_src();
    steps(2);
    check("bc_pndng_c2", 32'(pndng), 32'h0);
    check("bc_self_pndng_c2", 32'(pndng_s), 32'h0);
    step();
    check("bc_pndng_c3", 32'(pndng), 32'hB);
    check("bc_self_pndng_c3", 32'(pndng_s), 32'hF);
    check("bc_data0", 32'(data_out[15:0]), 32'hFF55);
    check("bc_data1", 32'(data_out[31:16]), 32'hFF55);
    check("bc_data2_empty", 32'(data_out[47:32]), 32'h0);
    check("bc_data3", 32'(data_out[63:48]), 32'hFF55);
    check("bc_self_data2", 32'(data_out_s[47:32]), 32'hFF55);

    // Backpressure: FIFO 3 full stalls a broadcast until one pop frees a slot
    do_reset();
    for (int n = 0; n < 16; n++) push_src(1, {8'h03, 8'(n)});
    update_src();
    steps(52);
    check("bp_fill_pndng", 32'(pndng), 32'h8);
    check("bp_fill_head", 32'(data_out[63:48]), 32'h0300);
    push_src(0, 16'hFF00);
    update_src();
    steps(6);
    check("bp_stall_busy", 32'(busy), 32'h1);
    check("bp_stall_pndng", 32'(pndng), 32'h8);
    pop[3] = 1'b1;
    step();
    check("bp_popcycle_pndng", 32'(pndng), 32'h8);
    check("bp_popcycle_busy", 32'(busy), 32'h1);
    check("bp_head3", 32'(data_out[63:48]), 32'h0301);
    step();
    check("bp_push_pndng", 32'(pndng), 32'hE);
    check("bp_push_data1", 32'(data_out[31:16]), 32'hFF00);
    check("bp_push_data2", 32'(data_out[47:32]), 32'hFF00);
    check("bp_push_busy", 32'(busy), 32'h0);

    // Invalid destination is dropped; counter saturates
    do_reset();
    push_src(0, 16'h0700);
    update_src();
    step();
    check("drop_popin", 32'(popin), 32'h1);
    steps(2);
    check("drop_pndng", 32'(pndng), 32'h0);
    check("drop_cnt1", 32'(drop_cnt), 32'h1);
    check("drop_busy", 32'(busy), 32'h0);
    force dut.drop_cnt = 16'hFFFF;
    step();
    release dut.drop_cnt;
    push_src(0, 16'h0701);
    update_src();
    steps(4);
    check("drop_sat", 32'(drop_cnt), 32'hFFFF);
    check("drop_sat_pndng", 32'(pndng), 32'h0);

    // Reset while a packet is in PUSH; afterwards terminal 0 wins first
    push_src(0, 16'h0212);
    update_src();
    steps(3);
    check("mid_pre_pndng", 32'(pndng), 32'h4);
    push_src(2, 16'h0112);
    update_src();
    steps(2);
    check("mid_in_push", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_popin", 32'(popin), 32'h0);
    check("mid_rst_pndng", 32'(pndng), 32'h0);
    check("mid_rst_data", data_out[31:0] | data_out[63:32], 32'h0);
    check("mid_rst_drop", 32'(drop_cnt), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    clear_src();
    @(posedge clk);
    #1;
    reset = 1'b1;
    push_src(1, 16'h0001);
    push_src(0, 16'h0000);
    update_src();
    step();
    check("mid_first_grant", 32'(popin), 32'h1);
    steps(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_bus_arbiter.md
# router_bus_arbiter

Parametrised, buffered bus fabric for the router test environment. It connects NUM_NTRFS terminals over a single shared bus. A round-robin arbiter pops one packet at a time from the requesting terminals' source FIFOs. Each packet is routed by its destination-ID field into per-terminal output FIFOs; broadcast delivery is all-or-nothing, and packets with invalid destinations are counted and dropped. It is the successor to the fixed bus generator and drives the same pop/popin/pndng signalling towards the agents.

## Interface
- NUM_NTRFS, 4, number of terminals (2..16)
- PCKG_SZ, 16, packet width in bits; must be ≥ ID_W+1
- ID_W, 8, destination-ID field width, located at bits [PCKG_SZ-1 -: ID_W]
- BROADCAST, {ID_W{1'b1}}, destination-ID value that means "all terminals"
- BCAST_SELF, 0, 1 = a broadcast is also delivered back to its source terminal
- FIFO_DEPTH, 16, entries per output FIFO (power of 2, ≥2)
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pndng_i_in  in  NUM_NTRFS  source FIFO of terminal i is non-empty
- data_out_i_in  in  NUM_NTRFS*PCKG_SZ  show-ahead head of source FIFO i; slice i is [i*PCKG_SZ +: PCKG_SZ]
- popin  out  NUM_NTRFS  one-cycle pop strobe to source FIFO i
- pop  in  NUM_NTRFS  terminal i consumes the head of its output FIFO
- pndng  out  NUM_NTRFS  output FIFO i is non-empty
- data_out  out  NUM_NTRFS*PCKG_SZ  show-ahead head of output FIFO i
- drop_cnt  out  16  count of dropped packets; saturates at 16'hFFFF
- busy  out  1  FSM is not in IDLE

## Operation
- FSM has three states: IDLE, POP, PUSH.
- IDLE, when any pndng_i_in is set:
  - choose a winner by round-robin, searching upward from last_grant+1 with wrap-around;
  - register the winner;
  - go to POP.
- POP:
  - popin[winner] = 1 for exactly this cycle;
  - latch the winner's data_out_i_in slice into pkt_q at the clock edge;
  - go to PUSH.
- PUSH: decode dst = pkt_q[PCKG_SZ-1 -: ID_W].
  - dst < NUM_NTRFS: the target set is {dst}. A packet addressed to its own source is delivered.
  - dst == BROADCAST: the target set is all terminals, excluding the source unless BCAST_SELF = 1.
  - Any other dst: drop the packet, increment drop_cnt (saturating), go to IDLE.
  - If every target FIFO has count < FIFO_DEPTH at the start of the cycle, push pkt_q into all of them in this same cycle and go to IDLE.
  - Otherwise stay in PUSH and retry every cycle. There are no partial broadcasts.
  - On leaving PUSH, last_grant ← winner.
- Output FIFO i:
  - pop[i] with pndng[i] = 1 removes the head;
  - pop[i] on an empty FIFO is ignored;
  - a push and a pop in the same cycle are both performed, and the count is unchanged;
  - when the FIFO is empty, data_out slice i = 0.
- Order is preserved per output FIFO.
- Reset value of last_grant is NUM_NTRFS-1, so terminal 0 is served first.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state = IDLE; popin = 0, pndng = 0, data_out = 0, drop_cnt = 0, busy = 0; all FIFOs are emptied.
- Reset during POP or PUSH: the in-flight packet is lost. If popin had already fired, the source entry is already consumed.
- Latency, with the request visible in cycle 0 of IDLE and no backpressure:
  - popin is high in cycle 1;
  - push happens at the end of cycle 2;
  - pndng[dst] rises in cycle 3.
- Throughput: at most one packet per 3 cycles.
- Each full target FIFO adds one cycle per stalled cycle. A pop that frees space in cycle n allows the push in cycle n+1.
- popin never asserts in IDLE or PUSH, and never for more than one terminal.
- busy is a registered decode of the state: high during POP and PUSH.

## Test plan
- Single unicast: terminal 1 sends 16'h02AB → popin[1] pulses once in cycle 1; pndng[2] = 1 in cycle 3 with data_out slice 2 = 16'h02AB; no other pndng asserts.
- Round-robin fairness: terminals 0, 1 and 3 request continuously with 2 packets each → grant order 0, 1, 3, 0, 1, 3; no terminal is served twice before another pending terminal.
- Broadcast: terminal 2 sends 16'hFF55 with BCAST_SELF = 0 → output FIFOs 0, 1 and 3 each receive 16'hFF55 in the same cycle; FIFO 2 stays empty. With BCAST_SELF = 1, all four FIFOs receive it.
- Backpressure: fill output FIFO 3 to FIFO_DEPTH, then send a broadcast from terminal 0 → FSM holds in PUSH and no FIFO is written. After one pop[3], all of FIFOs 1, 2 and 3 are written on the next cycle.
- Invalid destination: send 16'h0700 with NUM_NTRFS = 4 → popin pulses, no FIFO is written, drop_cnt goes 0 → 1. Force drop_cnt to 16'hFFFF and send another invalid packet → drop_cnt stays at 16'hFFFF.
- Reset mid-PUSH: assert reset while in PUSH → all outputs read 0 immediately. After release, the next request is granted to terminal 0 first.
